// File: rtl/lsu_ctrl.sv
// Load/store control ahead of the byte-lane data memory: lane select, store strobe, load extension.
// Latency: response RD_LAT+1 cycles after accept (1 cycle for misaligned/illegal requests).
// Backpressure: req_ready is low from accept until the response pulse; one request per RD_LAT+2 cycles.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [3:0]            mem_sel,
    output logic                  mem_str,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
    } req_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t state, state_n;
    req_t   req_q, req_n;
    logic [2:0] cnt, cnt_n;

    logic                  req_ready_n;
    logic                  resp_valid_n;
    logic                  resp_err_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n;
    logic [ADDR_WIDTH-1:0] mem_a_n;
    logic [3:0]            mem_sel_n;
    logic                  mem_str_n;
    logic [DATA_WIDTH-1:0] mem_wdata_n;

    logic                  misaligned;
    logic [3:0]            lane_sel;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic                  unused_addr_hi;

    // Upper byte-address bits fall outside the memory and simply wrap.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [1:0] size,
                                                     input logic sgn,
                                                     input logic [DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   extend = {{24{sgn & d[7]}}, d[7:0]};
            2'b01:   extend = {{16{sgn & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        lane_sel   = 4'b1111;
        lane_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                lane_sel   = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_sel   = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_n      = state;
        req_n        = req_q;
        cnt_n        = cnt;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        mem_a_n      = mem_A;
        mem_sel_n    = 4'b0000;
        mem_str_n    = 1'b0;
        mem_wdata_n  = mem_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_n = '{we: req_we, size: req_size, sgn: req_signed};
                    if (misaligned) begin
                        // Rejected requests never touch the memory interface.
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n     = ACCESS;
                        cnt_n       = '0;
                        mem_a_n     = req_addr[ADDR_WIDTH+1:2];
                        mem_sel_n   = lane_sel;
                        mem_str_n   = req_we;
                        mem_wdata_n = lane_wdata;
                    end
                end
            end
            ACCESS: begin
                mem_sel_n = mem_sel;
                if (cnt == LAST_CNT) begin
                    state_n      = RESP;
                    mem_sel_n    = 4'b0000;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = req_q.we ? '0 : extend(req_q.size, req_q.sgn, mem_rdata);
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q      <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_A      <= '0;
            mem_sel    <= 4'b0000;
            mem_str    <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            req_q      <= req_n;
            cnt        <= cnt_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_A      <= mem_a_n;
            mem_sel    <= mem_sel_n;
            mem_str    <= mem_str_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and random load/store requests against a behavioural model of lsu_ctrl (RD_LAT = 3).
module tb_lsu_ctrl;
    localparam int AW  = 10;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_A;
    logic [3:0]    mem_sel;
    logic          mem_str;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    int total = 0;
    int bad   = 0;
    bit in_resp = 1'b0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_A(mem_A), .mem_sel(mem_sel), .mem_str(mem_str),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the response cycle.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata);
        logic          err;
        logic [3:0]    e_sel;
        logic [31:0]   e_wd;
        logic [31:0]   e_rd;
        logic [AW-1:0] e_a;
        int            off;
        int            waited;
        off   = int'(addr % 4);
        err   = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
        e_a   = AW'(addr / 4);
        case (size)
            2'd0: begin
                e_sel = 4'(1 << off);
                e_wd  = 32'h0101_0101 * 32'(wdata[7:0]);
                e_rd  = (sgn && rdata[7]) ? 32'(rdata[7:0]) - 32'h100 : 32'(rdata[7:0]);
            end
            2'd1: begin
                e_sel = (off >= 2) ? 4'b1100 : 4'b0011;
                e_wd  = 32'h0001_0001 * 32'(wdata[15:0]);
                e_rd  = (sgn && rdata[15]) ? 32'(rdata[15:0]) - 32'h1_0000 : 32'(rdata[15:0]);
            end
            default: begin
                e_sel = 4'hF;
                e_wd  = wdata;
                e_rd  = rdata;
            end
        endcase
        if (we || err) e_rd = '0;

        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        waited = 0;
        while (!req_ready && waited < 8) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(waited), in_resp ? 32'd1 : 32'd0);
        @(posedge clk);
        if (err) begin
            @(negedge clk);
            chk("err_valid", 32'(resp_valid), 32'd1);
            chk("err_flag",  32'(resp_err),   32'd1);
            chk("err_rdata", resp_rdata,      32'd0);
            chk("err_sel",   32'(mem_sel),    32'd0);
            chk("err_str",   32'(mem_str),    32'd0);
            chk("err_ready", 32'(req_ready),  32'd0);
        end else begin
            for (int c = 1; c <= LAT; c++) begin
                @(negedge clk);
                chk("acc_valid", 32'(resp_valid), 32'd0);
                chk("acc_ready", 32'(req_ready),  32'd0);
                chk("acc_sel",   32'(mem_sel),    32'(e_sel));
                chk("acc_addr",  32'(mem_A),      32'(e_a));
                chk("acc_str",   32'(mem_str),    32'(we && c == 1));
                if (we) chk("acc_wdata", mem_wdata, e_wd);
                mem_rdata  = (c == LAT) ? rdata : $urandom;
                // Requests presented while busy must be ignored.
                req_valid  = 1'($urandom_range(0, 1));
                req_we     = 1'($urandom_range(0, 1));
                req_size   = 2'($urandom_range(0, 3));
                req_signed = 1'($urandom_range(0, 1));
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            @(negedge clk);
            chk("rsp_valid", 32'(resp_valid), 32'd1);
            chk("rsp_err",   32'(resp_err),   32'd0);
            chk("rsp_rdata", resp_rdata,      e_rd);
            chk("rsp_sel",   32'(mem_sel),    32'd0);
            chk("rsp_str",   32'(mem_str),    32'd0);
            chk("rsp_ready", 32'(req_ready),  32'd0);
        end
        req_valid = 1'b0;
        in_resp   = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_valid", 32'(resp_valid), 32'd0);
            chk("idle_ready", 32'(req_ready),  32'd1);
            chk("idle_str",   32'(mem_str),    32'd0);
        end
        in_resp = 1'b0;
    endtask

    initial begin
        logic [1:0] sz;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready),  32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err",   32'(resp_err),   32'd0);
        chk("rst_rdata", resp_rdata,      32'd0);
        chk("rst_sel",   32'(mem_sel),    32'd0);
        chk("rst_str",   32'(mem_str),    32'd0);
        chk("rst_addr",  32'(mem_A),      32'd0);
        chk("rst_wdata", mem_wdata,       32'd0);
        rst_n = 1'b1;
        idle(1);

        run_req(1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_00A5, 32'h0);
        idle(1);
        run_req(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 32'h0000_0080);
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_0080);
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 32'h0000_8001);
        run_req(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 32'h0000_8001);
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0);
        run_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678);
        run_req(1'b0, 2'd2, 1'b1, 32'h0000_0104, 32'h0, 32'h8765_4321);
        run_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0);
        run_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 32'h0);
        idle(1);

        // Reset while a word load is in its first access cycle.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_sel", 32'(mem_sel), 32'hF);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready),  32'd1);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_sel",   32'(mem_sel),    32'd0);
        chk("mid_rst_str",   32'(mem_str),    32'd0);
        chk("mid_rst_addr",  32'(mem_A),      32'd0);
        chk("mid_rst_rdata", resp_rdata,      32'd0);
        rst_n = 1'b1;
        idle(LAT + 2);

        repeat (80) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                    $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
